// File: rtl/nes_bus_pkg.sv
// Shared CPU-bus constants and the OAM DMA state type. Used by the cpu, the memory map
// and the OAM DMA arbiter.
package nes_bus_pkg;

  localparam logic [15:0] DMA_REG_ADDR_DEF  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR_DEF = 16'h2004;
  localparam int          PAGE_BYTES        = 256;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

endpackage

// File: rtl/oam_dma_arbiter.sv
// CPU bus arbiter that runs the 256-byte OAM DMA copy triggered by a CPU write to $4014.
// Define OAM_DMA_ALIGN_EN to add the odd-cycle alignment stall after the HALT cycle.
module oam_dma_arbiter
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEF,
  parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_write,
  input  logic [7:0]  mem_din,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_dout,
  output logic        bus_write,
  output logic        cpu_hold,
  output logic        dma_busy
);

`ifdef OAM_DMA_ALIGN_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  localparam logic [7:0] LAST_IDX = 8'(PAGE_BYTES - 1);

  dma_state_t state;
  logic [7:0] page;
  logic [7:0] idx;
  logic [7:0] data;
  logic       cycle_odd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      page      <= '0;
      idx       <= '0;
      data      <= '0;
      cycle_odd <= 1'b0;
    end else begin
      cycle_odd <= ~cycle_odd;
      unique case (state)
        IDLE: begin
          if (cpu_write && (cpu_addr == DMA_REG_ADDR)) begin
            page  <= cpu_dout;
            idx   <= '0;
            state <= HALT;
          end
        end
        HALT:  state <= (ALIGN_EN && cycle_odd) ? ALIGN : READ;
        ALIGN: state <= READ;
        READ: begin
          data  <= mem_din;
          state <= WRITE;
        end
        WRITE: begin
          // idx stops at the last byte; the page register is never advanced
          if (idx == LAST_IDX) begin
            state <= IDLE;
          end else begin
            idx   <= idx + 8'd1;
            state <= READ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus_addr  = cpu_addr;
    bus_dout  = cpu_dout;
    bus_write = cpu_write;
    cpu_hold  = (state != IDLE);
    dma_busy  = 1'b0;
    unique case (state)
      IDLE: ;
      HALT, ALIGN: begin
        bus_addr  = {page, 8'h00};
        bus_dout  = '0;
        bus_write = 1'b0;
      end
      READ: begin
        bus_addr  = {page, idx};
        bus_dout  = '0;
        bus_write = 1'b0;
        dma_busy  = 1'b1;
      end
      WRITE: begin
        bus_addr  = OAM_DATA_ADDR;
        bus_dout  = data;
        bus_write = 1'b1;
        dma_busy  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Bench for oam_dma_arbiter: idle passthrough table, random idle traffic, and full/aligned/
// aborted DMA copies checked cycle by cycle against a transaction-list model of the copy.
module tb_oam_dma_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_write;
  logic [7:0]  mem_din;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic        bus_write;
  logic        cpu_hold;
  logic        dma_busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc;

`ifdef OAM_DMA_ALIGN_EN
  localparam bit ALIGN_EN_TB = 1'b1;
`else
  localparam bit ALIGN_EN_TB = 1'b0;
`endif

  logic [7:0] mem [0:65535];
  assign mem_din = mem[bus_addr];

  oam_dma_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_addr  (cpu_addr),
    .cpu_dout  (cpu_dout),
    .cpu_write (cpu_write),
    .mem_din   (mem_din),
    .bus_addr  (bus_addr),
    .bus_dout  (bus_dout),
    .bus_write (bus_write),
    .cpu_hold  (cpu_hold),
    .dma_busy  (dma_busy)
  );

  always #5 clk = ~clk;

  // free-running cycle count since reset release; its parity is the expected cycle_odd
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  dout;
    logic        wr;
    logic [15:0] e_addr;
    logic [7:0]  e_dout;
    logic        e_wr;
    logic        e_hold;
  } vec_t;

  function automatic logic [31:0] pack(input logic [15:0] a, input logic [7:0] d,
                                       input logic w, input logic b, input logic h);
    return {5'b0, a, d, w, b, h};
  endfunction

  function automatic logic [31:0] obs();
    return {5'b0, bus_addr, bus_dout, bus_write, dma_busy, cpu_hold};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one DMA from the trigger write. want_par: required cycle_odd in HALT (-1 = any).
  // abort_writes > 0 returns right after that many DMA writes have been checked.
  task automatic run_dma(input logic [7:0] page, input int want_par, input int abort_writes);
    logic [31:0] exp_q[$];
    logic [31:0] e;
    logic        align;
    int          hold_cnt;
    int          writes;
    int          n;
    tick();
    cpu_write = 1'b0;
    cpu_addr  = 16'h0000;
    if (want_par >= 0 && ((cyc + 1) % 2) != want_par) tick();
    cpu_addr  = 16'h4014;
    cpu_dout  = page;
    cpu_write = 1'b1;
    align = ALIGN_EN_TB && (((cyc + 1) % 2) == 1);
    @(negedge clk);
    check("trigger_passthrough", obs(), pack(16'h4014, page, 1'b1, 1'b0, 1'b0));

    exp_q.push_back(pack({page, 8'h00}, 8'h00, 1'b0, 1'b0, 1'b1));
    if (align) exp_q.push_back(pack({page, 8'h00}, 8'h00, 1'b0, 1'b0, 1'b1));
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back(pack({page, 8'(i)}, 8'h00, 1'b0, 1'b1, 1'b1));
      exp_q.push_back(pack(16'h2004, mem[{page, 8'(i)}], 1'b1, 1'b1, 1'b1));
    end

    hold_cnt = 0;
    writes   = 0;
    n        = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tick();
      if (n % 7 == 3) begin
        cpu_addr  = 16'h4014;
        cpu_write = 1'b1;
      end else begin
        cpu_addr  = 16'($urandom);
        cpu_write = 1'($urandom);
      end
      cpu_dout = 8'($urandom);
      n++;
      @(negedge clk);
      check("dma_cycle", obs(), e);
      if (cpu_hold === 1'b1) hold_cnt++;
      if (e[2] && e[0]) writes++;
      if (abort_writes > 0 && writes == abort_writes) return;
    end

    tick();
    cpu_addr  = 16'h0100;
    cpu_dout  = 8'h3C;
    cpu_write = 1'b0;
    @(negedge clk);
    check("dma_done_idle", obs(), pack(16'h0100, 8'h3C, 1'b0, 1'b0, 1'b0));
    check("hold_cycles", 32'(hold_cnt), align ? 32'd514 : 32'd513);
    check("oam_writes", 32'(writes), 32'd256);
  endtask

  vec_t tbl [6];

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    tbl[0] = '{16'h4015, 8'h02, 1'b1, 16'h4015, 8'h02, 1'b1, 1'b0};
    tbl[1] = '{16'h4014, 8'h07, 1'b0, 16'h4014, 8'h07, 1'b0, 1'b0};
    tbl[2] = '{16'h0200, 8'h5A, 1'b1, 16'h0200, 8'h5A, 1'b1, 1'b0};
    tbl[3] = '{16'h2004, 8'h33, 1'b0, 16'h2004, 8'h33, 1'b0, 1'b0};
    tbl[4] = '{16'hFFFF, 8'hFF, 1'b1, 16'hFFFF, 8'hFF, 1'b1, 1'b0};
    tbl[5] = '{16'h0000, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0};

    rst = 1'b1;
    cpu_addr = 16'h0000;
    cpu_dout = 8'h00;
    cpu_write = 1'b0;
    #1;
    rst = 1'b0;
    cpu_addr = 16'h1234;
    cpu_dout = 8'hAB;
    cpu_write = 1'b1;
    #1;
    check("reset_passthrough", obs(), pack(16'h1234, 8'hAB, 1'b1, 1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b1;

    foreach (tbl[k]) begin
      tick();
      cpu_addr  = tbl[k].addr;
      cpu_dout  = tbl[k].dout;
      cpu_write = tbl[k].wr;
      @(negedge clk);
      check("idle_table", obs(),
            pack(tbl[k].e_addr, tbl[k].e_dout, tbl[k].e_wr, 1'b0, tbl[k].e_hold));
    end

    for (int k = 0; k < 16; k++) begin
      tick();
      cpu_addr = 16'($urandom);
      if (cpu_addr == 16'h4014) cpu_addr = 16'h4013;
      cpu_dout  = 8'($urandom);
      cpu_write = 1'($urandom);
      @(negedge clk);
      check("idle_random", obs(), pack(cpu_addr, cpu_dout, cpu_write, 1'b0, 1'b0));
    end

    run_dma(8'h02, 0, 0);
    run_dma(8'($urandom), 1, 0);
    run_dma(8'($urandom), -1, 0);

    run_dma(8'h11, -1, 100);
    tick();
    cpu_addr  = 16'h0777;
    cpu_dout  = 8'h44;
    cpu_write = 1'b0;
    rst = 1'b0;
    #1;
    check("abort_hold_drop", obs(), pack(16'h0777, 8'h44, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b1;
    run_dma(8'h03, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
